bp_bimodal: RTL and testbench

//  Dynamic branch predictor for the IF stage: PC-indexed BTB plus a table of 2-bit saturating counters.

---
 rtl/bp_bimodal_pkg.sv | 14 +
 rtl/bp_sat_cnt2.sv | 21 ++
 rtl/bp_bimodal.sv | 149 ++++++++++++++
 tb/tb_bp_bimodal.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bp_bimodal_pkg.sv
// Shared encodings for the bimodal branch predictor: 2-bit counter states and the B-type opcode.
package bp_bimodal_pkg;

    localparam logic [1:0] BP_CNT_SNT = 2'b00;
    localparam logic [1:0] BP_CNT_WNT = 2'b01;
    localparam logic [1:0] BP_CNT_WT  = 2'b10;
    localparam logic [1:0] BP_CNT_ST  = 2'b11;

    localparam logic [6:0] INST_TYPE_B = 7'b1100011;

    localparam logic JumpEnable  = 1'b1;
    localparam logic JumpDisable = 1'b0;

endpackage

// File: rtl/bp_sat_cnt2.sv
// 2-bit saturating up/down counter step, purely combinational.
// Latency 0; no flow control.
// Pins at strongly-taken / strongly-not-taken instead of wrapping.
module bp_sat_cnt2
    import bp_bimodal_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       inc_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != BP_CNT_ST) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != BP_CNT_SNT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/bp_bimodal.sv
// Bimodal predictor: PC-indexed BTB with 2-bit counters; combinational lookup, trained from EX.
// Latency: lookup 0 cycles, training visible the cycle after the update edge; no backpressure.
// Optional BP_BTFN_FALLBACK_EN: backward B-type branches predicted taken on a table miss.
module bp_bimodal
    import bp_bimodal_pkg::*;
#(
    parameter int         BP_ENTRIES  = 64,
    parameter int         BP_TAG_W    = 8,
    parameter logic [1:0] BP_CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    output logic        isbranch_o,
    output logic [31:0] branch_addr_o,
    input  logic        flush_i,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_mispred_i,
    output logic [31:0] perf_upd_o,
    output logic [31:0] perf_mispred_o
);

    localparam int IDX_W = $clog2(BP_ENTRIES);

    logic                valid_q [BP_ENTRIES];
    logic                valid_d [BP_ENTRIES];
    logic [1:0]          cnt_q   [BP_ENTRIES];
    logic [1:0]          cnt_d   [BP_ENTRIES];
    logic [BP_TAG_W-1:0] tag_q   [BP_ENTRIES];
    logic [BP_TAG_W-1:0] tag_d   [BP_ENTRIES];
    logic [31:0]         tgt_q   [BP_ENTRIES];
    logic [31:0]         tgt_d   [BP_ENTRIES];
    logic [31:0]         perf_upd_q, perf_upd_d;
    logic [31:0]         perf_mispred_q, perf_mispred_d;

    logic [IDX_W-1:0]    lk_idx, u_idx;
    logic [BP_TAG_W-1:0] lk_tag, u_tag;
    logic                lk_hit, u_hit;
    logic [1:0]          u_cnt_nxt;
    logic                unused_bits;

    assign lk_idx = inst_addr_i[IDX_W+1:2];
    assign lk_tag = inst_addr_i[IDX_W+BP_TAG_W+1:IDX_W+2];
    assign u_idx  = upd_pc_i[IDX_W+1:2];
    assign u_tag  = upd_pc_i[IDX_W+BP_TAG_W+1:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign unused_bits = ^{inst_i, inst_addr_i, upd_pc_i};

    bp_sat_cnt2 u_sat_cnt (
        .cnt_i (cnt_q[u_idx]),
        .inc_i (upd_taken_i),
        .cnt_o (u_cnt_nxt)
    );

`ifdef BP_BTFN_FALLBACK_EN
    logic [31:0] b_imm;
    logic        btfn_taken;

    assign b_imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign btfn_taken = (inst_i[6:0] == INST_TYPE_B) && inst_i[31];

    always_comb begin
        isbranch_o    = JumpDisable;
        branch_addr_o = 32'h0;
        if (lk_hit) begin
            if (cnt_q[lk_idx][1]) begin
                isbranch_o    = JumpEnable;
                branch_addr_o = tgt_q[lk_idx];
            end
        end else if (btfn_taken) begin
            isbranch_o    = JumpEnable;
            branch_addr_o = inst_addr_i + b_imm;
        end
    end
`else
    always_comb begin
        isbranch_o    = JumpDisable;
        branch_addr_o = 32'h0;
        if (lk_hit && cnt_q[lk_idx][1]) begin
            isbranch_o    = JumpEnable;
            branch_addr_o = tgt_q[lk_idx];
        end
    end
`endif

    // Flush wins over a same-cycle update; the update still counts in the perf counters.
    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (flush_i) begin
            for (int i = 0; i < BP_ENTRIES; i++) begin
                valid_d[i] = 1'b0;
                cnt_d[i]   = BP_CNT_INIT;
            end
        end else if (upd_valid_i) begin
            if (u_hit) begin
                cnt_d[u_idx] = u_cnt_nxt;
                if (upd_taken_i) tgt_d[u_idx] = upd_target_i;
            end else if (upd_taken_i) begin
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                tgt_d[u_idx]   = upd_target_i;
                cnt_d[u_idx]   = BP_CNT_WT;
            end
        end
    end

    always_comb begin
        perf_upd_d     = perf_upd_q;
        perf_mispred_d = perf_mispred_q;
        if (upd_valid_i && (perf_upd_q != 32'hFFFF_FFFF)) perf_upd_d = perf_upd_q + 32'd1;
        if (upd_valid_i && upd_mispred_i && (perf_mispred_q != 32'hFFFF_FFFF))
            perf_mispred_d = perf_mispred_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BP_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= BP_CNT_INIT;
            end
            perf_upd_q     <= 32'h0;
            perf_mispred_q <= 32'h0;
        end else begin
            valid_q        <= valid_d;
            cnt_q          <= cnt_d;
            perf_upd_q     <= perf_upd_d;
            perf_mispred_q <= perf_mispred_d;
        end
    end

    // Tag and target storage is qualified by valid, so it carries no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    assign perf_upd_o     = perf_upd_q;
    assign perf_mispred_o = perf_mispred_q;

endmodule

// File: tb/tb_bp_bimodal.sv
// Directed bench for bp_bimodal with the default 64-entry, 8-bit-tag configuration.
module tb_bp_bimodal;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_i = 32'h0;
    logic [31:0] inst_addr_i = 32'h0;
    logic        isbranch_o;
    logic [31:0] branch_addr_o;
    logic        flush_i = 1'b0;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = 32'h0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = 32'h0;
    logic        upd_mispred_i = 1'b0;
    logic [31:0] perf_upd_o;
    logic [31:0] perf_mispred_o;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_upd = 32'h0;
    logic [31:0] exp_mis = 32'h0;

    bp_bimodal dut (
        .clk            (clk),
        .rst            (rst),
        .inst_i         (inst_i),
        .inst_addr_i    (inst_addr_i),
        .isbranch_o     (isbranch_o),
        .branch_addr_o  (branch_addr_o),
        .flush_i        (flush_i),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_target_i   (upd_target_i),
        .upd_mispred_i  (upd_mispred_i),
        .perf_upd_o     (perf_upd_o),
        .perf_mispred_o (perf_mispred_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic mis);
        @(negedge clk);
        upd_valid_i   = 1'b1;
        upd_pc_i      = pc;
        upd_taken_i   = taken;
        upd_target_i  = tgt;
        upd_mispred_i = mis;
        exp_upd++;
        if (mis) exp_mis++;
        @(negedge clk);
        upd_valid_i   = 1'b0;
        upd_mispred_i = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_br,
                        input logic [31:0] exp_addr);
        inst_addr_i = pc;
        #1;
        chk({tag, "_br"}, {31'h0, isbranch_o}, {31'h0, exp_br});
        chk({tag, "_addr"}, branch_addr_o, exp_addr);
    endtask

    task automatic perf(input string tag);
        chk({tag, "_perf_upd"}, perf_upd_o, exp_upd);
        chk({tag, "_perf_mis"}, perf_mispred_o, exp_mis);
    endtask

    initial begin
        // 1: reset state
        #12;
        look("rst_lookup", 32'h100, 1'b0, 32'h0);
        perf("rst");
        @(negedge clk);
        rst = 1'b1;

        // 2: allocate weakly taken, then walk down to not taken
        upd(32'h100, 1'b1, 32'h80, 1'b1);
        look("alloc", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h0, 1'b1);
        look("nt1", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("nt2", 32'h100, 1'b0, 32'h0);

        // 3: saturate at strongly taken, then two not-taken reach weakly not taken
        for (int i = 0; i < 5; i++) upd(32'h204, 1'b1, 32'h1000, 1'b0);
        look("sat_st", 32'h204, 1'b1, 32'h1000);
        upd(32'h204, 1'b0, 32'h0, 1'b1);
        look("st_minus1", 32'h204, 1'b1, 32'h1000);
        upd(32'h204, 1'b0, 32'h0, 1'b1);
        look("st_minus2", 32'h204, 1'b0, 32'h0);
        perf("mid");

        // 4: tag covers pc[15:8]; bit 16 aliases, a different tag misses then replaces
        upd(32'h108, 1'b1, 32'h500, 1'b0);
        look("own", 32'h108, 1'b1, 32'h500);
        look("alias_hi", 32'h10108, 1'b1, 32'h500);
        look("other_tag", 32'h208, 1'b0, 32'h0);
        upd(32'h208, 1'b1, 32'h600, 1'b0);
        look("replaced_old", 32'h108, 1'b0, 32'h0);
        look("replaced_new", 32'h208, 1'b1, 32'h600);

        // 5: flush with a same-cycle update drops the table write but counts it
        @(negedge clk);
        flush_i      = 1'b1;
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h30C;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h700;
        exp_upd++;
        @(negedge clk);
        flush_i     = 1'b0;
        upd_valid_i = 1'b0;
        look("flush_old", 32'h208, 1'b0, 32'h0);
        look("flush_upd", 32'h30C, 1'b0, 32'h0);
        perf("flush");

        // same-cycle lookup and update on one entry sees pre-update contents
        @(negedge clk);
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h114;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'hA00;
        exp_upd++;
        look("same_cyc", 32'h114, 1'b0, 32'h0);
        @(negedge clk);
        upd_valid_i = 1'b0;
        look("after_same", 32'h114, 1'b1, 32'hA00);

        // 6: backward-branch fallback on a miss
        inst_i = 32'hFE00_0CE3;
`ifdef BP_BTFN_FALLBACK_EN
        look("btfn_back", 32'h400, 1'b1, 32'h3F8);
`else
        look("btfn_back", 32'h400, 1'b0, 32'h0);
`endif
        inst_i = 32'h0000_0463;
        look("btfn_fwd", 32'h400, 1'b0, 32'h0);
        inst_i = 32'h0;

        // mispredict counter holds at all-ones
        @(negedge clk);
        force dut.perf_mispred_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_mispred_q;
        upd(32'h118, 1'b0, 32'h0, 1'b1);
        exp_mis = 32'hFFFF_FFFF;
        perf("sat");

        // asynchronous reset mid-run clears state immediately
        #2;
        rst = 1'b0;
        #1;
        exp_upd = 32'h0;
        exp_mis = 32'h0;
        perf("arst");
        look("arst", 32'h114, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
